// File: rtl/amplitude_pkg.sv
// Shared quarter-turn phase types and helpers for the amplitude rotation datapath.
// Codes compose by modulo-4 addition, so a running phase is just a 2-bit sum.
package amplitude_pkg;

  typedef logic [1:0] phase_t;

  localparam phase_t PHASE_P1 = 2'd0;
  localparam phase_t PHASE_PI = 2'd1;
  localparam phase_t PHASE_M1 = 2'd2;
  localparam phase_t PHASE_MI = 2'd3;

  // Legacy alpha has exactly one nonzero component; all-zero alpha falls through to +1.
  function automatic phase_t alpha_to_phase(input logic signed [1:0] alpha_r,
                                            input logic signed [1:0] alpha_i);
    phase_t p;
    p = PHASE_P1;
    if (alpha_r == 2'sd1)       p = PHASE_P1;
    else if (alpha_r == -2'sd1) p = PHASE_M1;
    else if (alpha_i == 2'sd1)  p = PHASE_PI;
    else if (alpha_i == -2'sd1) p = PHASE_MI;
    return p;
  endfunction

  function automatic phase_t phase_add(input phase_t a, input phase_t b);
    phase_t s;
    s = a + b;
    return s;
  endfunction

endpackage

// File: rtl/amplitude_rotate_lane.sv
// Combinational quarter-turn rotation of one complex amplitude.
// Negating the most negative value either clamps (flagging sat) or wraps.
module amplitude_rotate_lane
  import amplitude_pkg::*;
#(
  parameter int COMPLEX_BIT = 24,
  parameter bit SATURATE    = 1'b1
) (
  input  logic signed [COMPLEX_BIT-1:0] amp_r,
  input  logic signed [COMPLEX_BIT-1:0] amp_i,
  input  phase_t                        phase,
  output logic signed [COMPLEX_BIT-1:0] out_r,
  output logic signed [COMPLEX_BIT-1:0] out_i,
  output logic                          sat
);

  localparam logic signed [COMPLEX_BIT-1:0] MIN_VAL = {1'b1, {(COMPLEX_BIT-1){1'b0}}};
  localparam logic signed [COMPLEX_BIT-1:0] MAX_VAL = {1'b0, {(COMPLEX_BIT-1){1'b1}}};

  logic                          w_satR;
  logic                          w_satI;
  logic signed [COMPLEX_BIT-1:0] w_negR;
  logic signed [COMPLEX_BIT-1:0] w_negI;

  assign w_satR = SATURATE && (amp_r == MIN_VAL);
  assign w_satI = SATURATE && (amp_i == MIN_VAL);
  assign w_negR = w_satR ? MAX_VAL : -amp_r;
  assign w_negI = w_satI ? MAX_VAL : -amp_i;

  always_comb begin
    out_r = amp_r;
    out_i = amp_i;
    sat   = 1'b0;
    case (phase)
      PHASE_P1: begin
        out_r = amp_r;
        out_i = amp_i;
        sat   = 1'b0;
      end
      PHASE_PI: begin
        out_r = w_negI;
        out_i = amp_r;
        sat   = w_satI;
      end
      PHASE_M1: begin
        out_r = w_negR;
        out_i = w_negI;
        sat   = w_satR | w_satI;
      end
      default: begin
        out_r = amp_i;
        out_i = w_negR;
        sat   = w_satR;
      end
    endcase
  end

endmodule

// File: rtl/amplitude_phase_pipe.sv
// Two-stage multi-lane quarter-turn phase rotator with optional per-lane running phase.
// S1 resolves the effective phase, S2 rotates; valid/ready with full throughput.
module amplitude_phase_pipe
  import amplitude_pkg::*;
#(
  parameter int COMPLEX_BIT = 24,
  parameter int LANES       = 4,
  parameter bit SATURATE    = 1'b1
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [LANES*COMPLEX_BIT-1:0] in_amp_r,
  input  logic [LANES*COMPLEX_BIT-1:0] in_amp_i,
  input  logic [LANES*2-1:0]           in_phase,
  input  logic                         in_acc_en,
  input  logic                         acc_clr,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [LANES*COMPLEX_BIT-1:0] out_amp_r,
  output logic [LANES*COMPLEX_BIT-1:0] out_amp_i,
  output logic [LANES*2-1:0]           out_phase,
  output logic [LANES-1:0]             out_sat,
  output logic                         sat_sticky
);

  localparam int DW = LANES * COMPLEX_BIT;

  logic              r_s1Valid;
  logic [DW-1:0]     r_s1AmpR;
  logic [DW-1:0]     r_s1AmpI;
  logic [LANES*2-1:0] r_s1Phase;
  logic [LANES*2-1:0] r_acc;

  logic              r_s2Valid;
  logic [DW-1:0]     r_outR;
  logic [DW-1:0]     r_outI;
  logic [LANES*2-1:0] r_outPhase;
  logic [LANES-1:0]  r_outSat;
  logic              r_satSticky;

  logic              w_s2Adv;
  logic              w_s1Adv;
  logic              w_accept;
  logic              w_s2Load;
  logic [LANES*2-1:0] w_effPhase;
  logic [DW-1:0]     w_rotR;
  logic [DW-1:0]     w_rotI;
  logic [LANES-1:0]  w_rotSat;

  assign w_s2Adv  = !r_s2Valid || out_ready;
  assign w_s1Adv  = !r_s1Valid || w_s2Adv;
  assign w_accept = in_valid && w_s1Adv;
  assign w_s2Load = w_s2Adv && r_s1Valid;

  // A concurrent clear makes this transfer see a zero accumulator.
  always_comb begin
    w_effPhase = in_phase;
    for (int k = 0; k < LANES; k++) begin
      if (in_acc_en && !acc_clr)
        w_effPhase[2*k +: 2] = phase_add(r_acc[2*k +: 2], in_phase[2*k +: 2]);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                      r_acc <= '0;
    else if (acc_clr)                r_acc <= '0;
    else if (w_accept && in_acc_en)  r_acc <= w_effPhase;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1Valid <= 1'b0;
      r_s1AmpR  <= '0;
      r_s1AmpI  <= '0;
      r_s1Phase <= '0;
    end else if (w_s1Adv) begin
      r_s1Valid <= in_valid;
      if (in_valid) begin
        r_s1AmpR  <= in_amp_r;
        r_s1AmpI  <= in_amp_i;
        r_s1Phase <= w_effPhase;
      end
    end
  end

  for (genvar k = 0; k < LANES; k++) begin : g_lane
    amplitude_rotate_lane #(
      .COMPLEX_BIT(COMPLEX_BIT),
      .SATURATE   (SATURATE)
    ) u_lane (
      .amp_r (r_s1AmpR[k*COMPLEX_BIT +: COMPLEX_BIT]),
      .amp_i (r_s1AmpI[k*COMPLEX_BIT +: COMPLEX_BIT]),
      .phase (r_s1Phase[2*k +: 2]),
      .out_r (w_rotR[k*COMPLEX_BIT +: COMPLEX_BIT]),
      .out_i (w_rotI[k*COMPLEX_BIT +: COMPLEX_BIT]),
      .sat   (w_rotSat[k])
    );
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s2Valid  <= 1'b0;
      r_outR     <= '0;
      r_outI     <= '0;
      r_outPhase <= '0;
      r_outSat   <= '0;
    end else if (w_s2Adv) begin
      r_s2Valid <= r_s1Valid;
      if (r_s1Valid) begin
        r_outR     <= w_rotR;
        r_outI     <= w_rotI;
        r_outPhase <= r_s1Phase;
        r_outSat   <= w_rotSat;
      end
    end
  end

  // A saturation entering the output register beats a same-cycle clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_satSticky <= 1'b0;
    else        r_satSticky <= (r_satSticky && !acc_clr) || (w_s2Load && (|w_rotSat));
  end

  assign in_ready   = w_s1Adv;
  assign out_valid  = r_s2Valid;
  assign out_amp_r  = r_outR;
  assign out_amp_i  = r_outI;
  assign out_phase  = r_outPhase;
  assign out_sat    = r_outSat;
  assign sat_sticky = r_satSticky;

endmodule
